// File: rtl/snow64_bfloat16_fpu_arbiter_pkg.sv
// Shared types and widths for the BFloat16 FPU arbiter.
package snow64_bfloat16_fpu_arbiter_pkg;

  localparam int unsigned MSB_POS__SNOW64_BFLOAT16_FPU_OPER = 1;
  localparam int unsigned OPER_W = MSB_POS__SNOW64_BFLOAT16_FPU_OPER + 1;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [OPER_W-1:0] {
    OpAdd,
    OpSub,
    OpSlt,
    OpMul
  } fpu_oper_e;

  typedef enum logic {
    StFpuArbIdle,
    StFpuArbWait
  } fpu_arb_state_e;

  typedef struct packed {
    logic              start;
    logic [OPER_W-1:0] oper;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } fpu_arb_req_t;

  typedef struct packed {
    logic              valid;
    logic              error;
    logic [DATA_W-1:0] data;
  } fpu_arb_resp_t;

endpackage

// File: rtl/snow64_bfloat16_fpu_arbiter_picker.sv
// Combinational rotate-priority picker: first set request at or above ptr, wrapping.
module snow64_bfloat16_fpu_arbiter_picker #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        any           = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/snow64_bfloat16_fpu_arbiter.sv
// Round-robin arbiter sharing one BFloat16 FPU among NUM_REQ requesters.
// Optional watchdog enabled by SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN.
module snow64_bfloat16_fpu_arbiter
  import snow64_bfloat16_fpu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_start,
  input  logic [NUM_REQ*OPER_W-1:0] req_oper,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_accepted,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_error,
  output logic                      busy,
  output logic                      fpu_start,
  output logic [OPER_W-1:0]         fpu_oper,
  output logic [DATA_W-1:0]         fpu_a,
  output logic [DATA_W-1:0]         fpu_b,
  input  logic                      fpu_valid,
  input  logic                      fpu_can_accept_cmd,
  input  logic [DATA_W-1:0]         fpu_data
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_cfg_check
    $error("snow64_bfloat16_fpu_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  fpu_arb_state_e   state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] next_ptr;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] grant_oh;
  logic             pick_any;
  logic             grant_c;
  fpu_arb_req_t     reqs [NUM_REQ];
  fpu_arb_resp_t    resp_q;

`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
  logic [7:0] wd_cnt;
`endif

  // Unpack the flat requester buses into per-requester records.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      reqs[i] = '{start: req_start[i],
                  oper:  req_oper[i*OPER_W +: OPER_W],
                  a:     req_a[i*DATA_W +: DATA_W],
                  b:     req_b[i*DATA_W +: DATA_W]};
      pick_req[i] = reqs[i].start;
    end
  end

  snow64_bfloat16_fpu_arbiter_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req       (pick_req),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (pick_any)
  );

  // Accept is zero-latency, so the command path is combinational from the grant.
  assign grant_c      = (state == StFpuArbIdle) && !rst && fpu_can_accept_cmd && pick_any;
  assign req_accepted = grant_c ? grant_oh : '0;
  assign fpu_start    = grant_c;
  assign fpu_oper     = grant_c ? reqs[grant_idx].oper : '0;
  assign fpu_a        = grant_c ? reqs[grant_idx].a    : '0;
  assign fpu_b        = grant_c ? reqs[grant_idx].b    : '0;
  assign next_ptr     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(grant_idx + 1'b1);

  assign resp_valid = resp_q.valid ? (NUM_REQ'(1) << owner) : '0;
  assign resp_data  = resp_q.data;
  assign resp_error = resp_q.error;
  assign busy       = (state == StFpuArbWait);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= StFpuArbIdle;
      rr_ptr <= '0;
      owner  <= '0;
      resp_q <= '0;
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
      wd_cnt <= '0;
`endif
    end else begin
      resp_q.valid <= 1'b0;
      case (state)
        StFpuArbIdle: begin
          if (grant_c) begin
            owner  <= grant_idx;
            rr_ptr <= next_ptr;
            state  <= StFpuArbWait;
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        StFpuArbWait: begin
          if (fpu_valid) begin
            resp_q <= '{valid: 1'b1, error: 1'b0, data: fpu_data};
            state  <= StFpuArbIdle;
          end
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
          // Counter reaching the limit this edge reports an error response next cycle.
          else if (wd_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            resp_q <= '{valid: 1'b1, error: 1'b1, data: '0};
            state  <= StFpuArbIdle;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
`endif
        end
        default: state <= StFpuArbIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_bfloat16_fpu_arbiter.sv
// Self-checking bench for snow64_bfloat16_fpu_arbiter with a behavioural FPU and arbiter model.
module tb_snow64_bfloat16_fpu_arbiter;
  import snow64_bfloat16_fpu_arbiter_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;
  localparam int unsigned OW = OPER_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_start;
  logic [N*OW-1:0] req_oper;
  logic [N*16-1:0] req_a, req_b;
  logic [N-1:0]    req_accepted, resp_valid;
  logic [15:0]     resp_data;
  logic            resp_error, busy, fpu_start;
  logic [OW-1:0]   fpu_oper;
  logic [15:0]     fpu_a, fpu_b;
  logic            fpu_valid, fpu_can_accept_cmd;
  logic [15:0]     fpu_data;

  always #5 clk = ~clk;

  snow64_bfloat16_fpu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_oper(req_oper),
    .req_a(req_a), .req_b(req_b), .req_accepted(req_accepted),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .busy(busy), .fpu_start(fpu_start), .fpu_oper(fpu_oper), .fpu_a(fpu_a),
    .fpu_b(fpu_b), .fpu_valid(fpu_valid), .fpu_can_accept_cmd(fpu_can_accept_cmd),
    .fpu_data(fpu_data));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // FPU model: fixed latency after fpu_start, optional hang, result chosen by the bench.
  int          fpu_lat = 3;
  bit          fpu_hang = 1'b0;
  bit          fpu_fixed_en = 1'b0;
  logic [15:0] fpu_fixed = '0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_data = '0;

  initial begin
    fpu_valid = 1'b0;
    fpu_data  = '0;
    forever begin
      @(posedge clk); #1;
      fpu_valid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend = 1'b0;
          if (!fpu_hang) begin
            fpu_valid = 1'b1;
            fpu_data  = pend_data;
          end
        end
      end
      @(negedge clk);
      if (fpu_start) begin
        pend      = 1'b1;
        pend_cnt  = fpu_lat;
        pend_data = fpu_fixed_en ? fpu_fixed : 16'($urandom);
      end
    end
  end

  // Reference model of the arbiter, evaluated once per cycle at the falling edge.
  int          cyc_n = 0;
  bit          m_busy = 1'b0, m_rv = 1'b0, m_rerr = 1'b0;
  int          m_ptr = 0, m_owner = 0, m_wait = 0, m_rowner = 0;
  logic [15:0] m_rdata = '0;
  int          acc_log[$], acc_cyc[$], resp_own[$], resp_cyc[$], resp_err[$];
  logic [15:0] resp_dat[$];

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete(); resp_own.delete();
    resp_cyc.delete(); resp_err.delete(); resp_dat.delete();
  endtask

  task automatic cyc(output int g);
    logic [N-1:0]  exp_acc, exp_rv;
    logic [15:0]   ea, eb;
    logic [OW-1:0] eo;
    @(negedge clk);
    g = -1;
    if (!m_busy && !rst && fpu_can_accept_cmd)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_start[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_acc = '0; ea = '0; eb = '0; eo = '0;
    if (g >= 0) begin
      exp_acc[g] = 1'b1;
      ea = req_a[g*16 +: 16];
      eb = req_b[g*16 +: 16];
      eo = req_oper[g*OW +: OW];
    end
    exp_rv = '0;
    if (m_rv) exp_rv[m_rowner] = 1'b1;
    chk("req_accepted", 32'(req_accepted), 32'(exp_acc));
    chk("fpu_start", 32'(fpu_start), 32'(g >= 0));
    chk("fpu_oper", 32'(fpu_oper), 32'(eo));
    chk("fpu_a", 32'(fpu_a), 32'(ea));
    chk("fpu_b", 32'(fpu_b), 32'(eb));
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_rv) begin
      chk("resp_data", 32'(resp_data), 32'(m_rdata));
      chk("resp_error", 32'(resp_error), 32'(m_rerr));
      resp_own.push_back(m_rowner); resp_cyc.push_back(cyc_n);
      resp_err.push_back(int'(m_rerr)); resp_dat.push_back(m_rdata);
    end
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_rv = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (g >= 0) begin
        m_busy = 1'b1; m_owner = g; m_ptr = (g + 1) % N; m_wait = 0;
        acc_log.push_back(g); acc_cyc.push_back(cyc_n);
      end else if (m_busy) begin
        if (fpu_valid) begin
          m_rv = 1'b1; m_rerr = 1'b0; m_rdata = fpu_data; m_rowner = m_owner; m_busy = 1'b0;
        end
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TO) begin
            m_rv = 1'b1; m_rerr = 1'b1; m_rdata = '0; m_rowner = m_owner; m_busy = 1'b0;
          end
        end
`endif
      end
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic set_req(input int i);
    req_start[i]          = 1'b1;
    req_oper[i*OW +: OW]  = OW'($urandom);
    req_a[i*16 +: 16]     = 16'($urandom);
    req_b[i*16 +: 16]     = 16'($urandom);
  endtask

  task automatic do_reset();
    int g;
    rst = 1'b1;
    req_start = '0;
    cyc(g);
    cyc(g);
    rst = 1'b0;
  endtask

  task automatic drain();
    int g;
    for (int k = 0; k < 40 && (m_busy || m_rv); k++) cyc(g);
    chk("drain_bound", 32'(m_busy || m_rv), 32'd0);
  endtask

  initial begin
    int g, c0, target;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_start = '0; req_oper = '0; req_a = '0; req_b = '0;
    fpu_can_accept_cmd = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Reset values
    chk("rst_req_accepted", 32'(req_accepted), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fpu_start", 32'(fpu_start), 32'd0);

    // Single request: requester 2, 1.0 + 2.0 = 3.0, 3-cycle FPU
    clear_logs();
    fpu_lat = 3; fpu_fixed_en = 1'b1; fpu_fixed = 16'h4040;
    req_start[2] = 1'b1;
    req_oper[2*OW +: OW] = OpAdd;
    req_a[2*16 +: 16] = 16'h3F80;
    req_b[2*16 +: 16] = 16'h4000;
    for (int k = 0; k < 10; k++) begin
      cyc(g);
      if (g >= 0) req_start[g] = 1'b0;
    end
    chk("single_grant", 32'(qget(acc_log, 0)), 32'd2);
    chk("single_owner", 32'(qget(resp_own, 0)), 32'd2);
    chk("single_latency", 32'(qget(resp_cyc, 0) - qget(acc_cyc, 0)), 32'd4);
    chk("single_data", 32'(resp_dat.size() > 0 ? resp_dat[0] : 16'hxxxx), 32'h4040);
    fpu_fixed_en = 1'b0;

    // All requesters held: rotation and back-to-back spacing
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) set_req(i);
    for (int k = 0; k < 60 && acc_log.size() < 5; k++) begin
      cyc(g);
      if (g >= 0) set_req(g);
    end
    req_start = '0;
    drain();
    for (int i = 0; i < 5; i++) begin
      chk("rotate_grant", 32'(qget(acc_log, i)), 32'(exp_order[i]));
      chk("rotate_owner", 32'(qget(resp_own, i)), 32'(exp_order[i]));
    end
    for (int i = 0; i < 4; i++)
      chk("rotate_spacing", 32'(qget(acc_cyc, i + 1) - qget(acc_cyc, i)), 32'd4);

    // FPU not accepting for 5 cycles with requester 1 pending
    clear_logs();
    fpu_can_accept_cmd = 1'b0;
    set_req(1);
    for (int k = 0; k < 5; k++) cyc(g);
    chk("blocked_no_accept", 32'(acc_log.size()), 32'd0);
    fpu_can_accept_cmd = 1'b1;
    target = cyc_n;
    cyc(g);
    req_start[1] = 1'b0;
    chk("blocked_grant", 32'(qget(acc_log, 0)), 32'd1);
    chk("blocked_grant_cycle", 32'(qget(acc_cyc, 0)), 32'(target));
    drain();

    // Reset while waiting; stale fpu_valid afterwards must be ignored
    clear_logs();
    set_req(2);
    for (int k = 0; k < 5 && acc_log.size() == 0; k++) begin
      cyc(g);
      if (g >= 0) req_start[g] = 1'b0;
    end
    cyc(g);
    chk("wait_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc(g);
    rst = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_resp_data", 32'(resp_data), 32'd0);
    chk("post_rst_resp_error", 32'(resp_error), 32'd0);
    for (int k = 0; k < 5; k++) cyc(g);
    chk("stale_no_resp", 32'(resp_own.size()), 32'd0);
    set_req(1); set_req(3);
    cyc(g);
    req_start = '0;
    chk("post_rst_ptr_grant", 32'(qget(acc_log, 1)), 32'd1);
    drain();

    // FPU never answers
    clear_logs();
    fpu_hang = 1'b1;
    set_req(0);
    cyc(g);
    req_start[0] = 1'b0;
    c0 = qget(acc_cyc, 0);
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
    for (int k = 0; k < 20; k++) cyc(g);
    chk("timeout_owner", 32'(qget(resp_own, 0)), 32'd0);
    chk("timeout_delay", 32'(qget(resp_cyc, 0) - c0), 32'd9);
    chk("timeout_error", 32'(qget(resp_err, 0)), 32'd1);
    chk("timeout_busy_after", 32'(busy), 32'd0);
`else
    for (int k = 0; k < 100; k++) cyc(g);
    chk("hang_accepted", 32'(c0 >= 0), 32'd1);
    chk("hang_no_resp", 32'(resp_own.size()), 32'd0);
    chk("hang_busy", 32'(busy), 32'd1);
`endif
    fpu_hang = 1'b0;
    for (int k = 0; k < 6; k++) cyc(g);
    do_reset();

    // Randomized traffic against the model
    clear_logs();
    for (int k = 0; k < 800; k++) begin
      fpu_can_accept_cmd = ($urandom_range(3) != 0);
      fpu_lat = $urandom_range(5, 1);
      for (int i = 0; i < N; i++)
        if (!req_start[i] && $urandom_range(2) == 0) set_req(i);
      cyc(g);
      if (g >= 0) req_start[g] = 1'b0;
    end
    req_start = '0;
    fpu_can_accept_cmd = 1'b1;
    drain();
    chk("rand_resp_count", 32'(resp_own.size()), 32'(acc_log.size()));
    for (int i = 0; i < acc_log.size(); i++)
      if (qget(resp_own, i) != acc_log[i])
        chk("rand_resp_order", 32'(qget(resp_own, i)), 32'(acc_log[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
